// File: rtl/mips_pkg.sv
// Shared MIPS datapath definitions: operand width, mult/div op encodings, MDU FSM states.
package mips_pkg;

    localparam int unsigned MDU_WIDTH = 32;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        MUL  = 2'b01,
        DIV  = 2'b10,
        FIX  = 2'b11
    } state_e;

endpackage

// File: rtl/mdu_sign_fix.sv
// Combinational sign helper for the multiply/divide unit.
//   i_a, i_b, i_sgn      : raw operands and signed-op flag
//   o_abs_a, o_abs_b     : operand magnitudes (pass-through for unsigned ops)
//   i_res                : raw magnitude result {upper, lower}
//   i_is_div             : result is {remainder, quotient} instead of a product
//   i_neg_res, i_neg_rem : negate product/quotient, negate remainder
//   o_fix                : sign-corrected result {hi, lo}
module mdu_sign_fix #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0]   i_a,
    input  logic [WIDTH-1:0]   i_b,
    input  logic               i_sgn,
    output logic [WIDTH-1:0]   o_abs_a,
    output logic [WIDTH-1:0]   o_abs_b,
    input  logic [2*WIDTH-1:0] i_res,
    input  logic               i_is_div,
    input  logic               i_neg_res,
    input  logic               i_neg_rem,
    output logic [2*WIDTH-1:0] o_fix
);

    function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] x);
        return ~x + WIDTH'(1);
    endfunction

    logic [WIDTH-1:0] w_hi;
    logic [WIDTH-1:0] w_lo;

    // Operand magnitudes; the most negative value maps to itself, which is correct as unsigned.
    always_comb begin
        o_abs_a = (i_sgn && i_a[WIDTH-1]) ? neg_w(i_a) : i_a;
        o_abs_b = (i_sgn && i_b[WIDTH-1]) ? neg_w(i_b) : i_b;
    end

    // Result correction: full-width negate for a product, per-half negate for quotient/remainder.
    always_comb begin
        w_hi = i_res[2*WIDTH-1:WIDTH];
        w_lo = i_res[WIDTH-1:0];
        if (i_is_div) begin
            o_fix = {(i_neg_rem ? neg_w(w_hi) : w_hi), (i_neg_res ? neg_w(w_lo) : w_lo)};
        end else begin
            o_fix = i_neg_res ? (~i_res + (2*WIDTH)'(1)) : i_res;
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
//   clk, rst_n      : clock, async active-low reset
//   start, op       : request (sampled in IDLE) and op select MULT/MULTU/DIV/DIVU
//   rs_data/rt_data : operand A / dividend, operand B / divisor
//   hi_we, lo_we    : MTHI / MTLO strobes with wdata
//   busy, done      : operation in flight, one-cycle result pulse
//   hi, lo          : HI / LO registers
module mult_div_unit
    import mips_pkg::*;
#(
    parameter int unsigned WIDTH = MDU_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    state_e             r_state;
    state_e             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [2*WIDTH-1:0] r_p;
    logic [WIDTH-1:0]   r_b;
    logic               r_is_div;
    logic               r_neg_res;
    logic               r_neg_rem;
    logic               r_div0;
    logic [WIDTH-1:0]   r_rs_orig;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_busy;
    logic               r_done;

    logic               w_load;
    logic               w_iter;
    logic               w_fix;
    logic               w_mt_hi;
    logic               w_mt_lo;
    logic               w_signed;
    logic [WIDTH-1:0]   w_abs_a;
    logic [WIDTH-1:0]   w_abs_b;
    logic [2*WIDTH-1:0] w_fix_res;
    logic [WIDTH:0]     w_mul_sum;
    logic [2*WIDTH-1:0] w_mul_nxt;
    logic [WIDTH:0]     w_div_trial;
    logic [2*WIDTH-1:0] w_div_nxt;

    assign w_signed = (op == OP_MULT) || (op == OP_DIV);

    mdu_sign_fix #(.WIDTH(WIDTH)) u_sign_fix (
        .i_a       (rs_data),
        .i_b       (rt_data),
        .i_sgn     (w_signed),
        .o_abs_a   (w_abs_a),
        .o_abs_b   (w_abs_b),
        .i_res     (r_p),
        .i_is_div  (r_is_div),
        .i_neg_res (r_neg_res),
        .i_neg_rem (r_neg_rem),
        .o_fix     (w_fix_res)
    );

    // Shift-add step: r_p = {partial product, remaining multiplier bits}.
    always_comb begin
        w_mul_sum = {1'b0, r_p[2*WIDTH-1:WIDTH]} + (r_p[0] ? {1'b0, r_b} : (WIDTH+1)'(0));
        w_mul_nxt = {w_mul_sum, r_p[WIDTH-1:1]};
    end

    // Restoring step: r_p = {partial remainder, dividend/quotient bits}; trial bit WIDTH is the borrow.
    always_comb begin
        w_div_trial = r_p[2*WIDTH-1:WIDTH-1] - {1'b0, r_b};
        if (w_div_trial[WIDTH]) begin
            w_div_nxt = {r_p[2*WIDTH-2:0], 1'b0};
        end else begin
            w_div_nxt = {w_div_trial[WIDTH-1:0], r_p[WIDTH-2:0], 1'b1};
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and datapath strobes; start takes priority over MT writes in IDLE.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_iter      = 1'b0;
        w_fix       = 1'b0;
        w_mt_hi     = 1'b0;
        w_mt_lo     = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_load      = 1'b1;
                    w_state_nxt = op[1] ? DIV : MUL;
                end else begin
                    w_mt_hi = hi_we;
                    w_mt_lo = lo_we;
                end
            end
            MUL, DIV: begin
                w_iter = 1'b1;
                if (r_cnt == CNT_W'(WIDTH - 1)) begin
                    w_state_nxt = FIX;
                end
            end
            FIX: begin
                w_fix       = 1'b1;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Datapath, HI/LO and handshake registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_p       <= '0;
            r_b       <= '0;
            r_is_div  <= 1'b0;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
            r_div0    <= 1'b0;
            r_rs_orig <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_busy <= (w_state_nxt != IDLE);
            r_done <= w_fix;
            if (w_load) begin
                r_p       <= {{WIDTH{1'b0}}, w_abs_a};
                r_b       <= w_abs_b;
                r_cnt     <= '0;
                r_is_div  <= op[1];
                r_neg_res <= w_signed && (rs_data[WIDTH-1] ^ rt_data[WIDTH-1]);
                r_neg_rem <= w_signed && rs_data[WIDTH-1];
                r_div0    <= (rt_data == '0);
                r_rs_orig <= rs_data;
            end else if (w_iter) begin
                r_p   <= r_is_div ? w_div_nxt : w_mul_nxt;
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (w_fix) begin
                if (r_is_div && r_div0) begin
                    r_hi <= r_rs_orig;
                    r_lo <= {WIDTH{1'b1}};
                end else begin
                    r_hi <= w_fix_res[2*WIDTH-1:WIDTH];
                    r_lo <= w_fix_res[WIDTH-1:0];
                end
            end
            if (w_mt_hi) begin
                r_hi <= wdata;
            end
            if (w_mt_lo) begin
                r_lo <= wdata;
            end
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: stimulus pushes reference results, a monitor checks on done.
module tb_mult_div_unit;

    localparam int unsigned W = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] rs_data;
    logic [W-1:0] rt_data;
    logic         hi_we;
    logic         lo_we;
    logic [W-1:0] wdata;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    always #5 clk = ~clk;

    mult_div_unit #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .op      (op),
        .rs_data (rs_data),
        .rt_data (rt_data),
        .hi_we   (hi_we),
        .lo_we   (lo_we),
        .wdata   (wdata),
        .busy    (busy),
        .done    (done),
        .hi      (hi),
        .lo      (lo)
    );

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int unsigned start_edge;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        mon_e;
    int unsigned cyc = 0;
    int          checks = 0;
    int          passes = 0;
    logic [31:0] cur_hi = '0;
    logic [31:0] cur_lo = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference: plain 64-bit arithmetic; division truncates toward zero.
    function automatic logic [63:0] ref_model(input logic [1:0] o, input logic [31:0] a,
                                              input logic [31:0] b);
        longint          sa = $signed(a);
        longint          sb = $signed(b);
        longint unsigned ua = a;
        longint unsigned ub = b;
        longint          q;
        longint          r;
        longint unsigned uq;
        longint unsigned ur;
        case (o)
            2'b00: return 64'(sa * sb);
            2'b01: return ua * ub;
            2'b10: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            default: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                uq = ua / ub;
                ur = ua % ub;
                return {ur[31:0], uq[31:0]};
            end
        endcase
    endfunction

    // Call at a negedge with the unit idle; returns at the negedge after the start edge.
    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] r;
        exp_t        e;
        r            = ref_model(o, a, b);
        e.hi         = r[63:32];
        e.lo         = r[31:0];
        e.start_edge = cyc + 1;
        sb_q.push_back(e);
        start   = 1'b1;
        op      = o;
        rs_data = a;
        rt_data = b;
        @(negedge clk);
        start   = 1'b0;
        op      = 2'($urandom);
        rs_data = $urandom;
        rt_data = $urandom;
    endtask

    task automatic wait_not_busy();
        int n = 0;
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (busy) chk("busy_timeout", 64'(busy), 64'(0));
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy || sb_q.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (busy || sb_q.size() != 0) chk("idle_timeout", 64'(sb_q.size()), 64'(0));
    endtask

    task automatic mt_write(input logic h, input logic l, input logic [31:0] d);
        logic [31:0] eh;
        logic [31:0] el;
        eh    = h ? d : cur_hi;
        el    = l ? d : cur_lo;
        hi_we = h;
        lo_we = l;
        wdata = d;
        @(negedge clk);
        hi_we = 1'b0;
        lo_we = 1'b0;
        chk("mt_hi", 64'(hi), 64'(eh));
        chk("mt_lo", 64'(lo), 64'(el));
        cur_hi = eh;
        cur_lo = el;
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h1;
            default: return $urandom;
        endcase
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expected result.
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_done", 64'(done), 64'(0));
            end else begin
                mon_e = sb_q.pop_front();
                chk("result_hi", 64'(hi), 64'(mon_e.hi));
                chk("result_lo", 64'(lo), 64'(mon_e.lo));
                chk("latency", 64'(cyc - mon_e.start_edge), 64'(33));
                cur_hi = mon_e.hi;
                cur_lo = mon_e.lo;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        int dcnt;
        rst_n   = 1'b0;
        start   = 1'b0;
        op      = 2'b00;
        rs_data = '0;
        rt_data = '0;
        hi_we   = 1'b0;
        lo_we   = 1'b0;
        wdata   = '0;
        repeat (2) @(negedge clk);
        chk("reset_hi", 64'(hi), 64'(0));
        chk("reset_lo", 64'(lo), 64'(0));
        chk("reset_busy_done", 64'({busy, done}), 64'(0));
        rst_n = 1'b1;
        @(negedge clk);

        // MULTU max x max with busy window over the 33 cycles.
        issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        bad = 0;
        for (int k = 0; k < 33; k++) begin
            if (!busy) bad++;
            @(negedge clk);
        end
        if (busy) bad++;
        chk("busy_window", 64'(bad), 64'(0));
        wait_idle();

        // Signed multiply, then back-to-back divides with boundary cases.
        issue(2'b00, 32'hFFFF_FFFD, 32'h7);
        wait_not_busy();
        issue(2'b00, 32'h8000_0000, 32'h8000_0000);
        wait_not_busy();
        issue(2'b10, 32'hFFFF_FFF9, 32'h2);
        wait_not_busy();
        issue(2'b11, 32'd100, 32'd7);
        wait_not_busy();
        issue(2'b10, 32'h1234_5678, 32'h0);
        wait_not_busy();
        issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_idle();

        // start and MTHI while busy are both dropped.
        issue(2'b11, 32'hFFFF_FFF0, 32'd3);
        repeat (4) @(negedge clk);
        start   = 1'b1;
        hi_we   = 1'b1;
        wdata   = 32'hDEAD_BEEF;
        op      = 2'b00;
        rs_data = $urandom;
        @(negedge clk);
        start = 1'b0;
        hi_we = 1'b0;
        chk("hi_hold_busy", 64'(hi), 64'(cur_hi));
        wait_idle();

        // MT writes in IDLE.
        mt_write(1'b0, 1'b1, 32'hCAFE_BABE);
        mt_write(1'b1, 1'b1, 32'h5A5A_A5A5);

        // start together with MTHI: op runs, hi untouched until FIX.
        sb_q.push_back('{hi: 32'h0, lo: 32'd15, start_edge: cyc + 1});
        start   = 1'b1;
        op      = 2'b01;
        rs_data = 32'd3;
        rt_data = 32'd5;
        hi_we   = 1'b1;
        wdata   = 32'h1111_1111;
        @(negedge clk);
        start = 1'b0;
        hi_we = 1'b0;
        chk("start_busy", 64'(busy), 64'(1));
        repeat (10) @(negedge clk);
        chk("hi_hold_start_mt", 64'(hi), 64'(cur_hi));
        wait_idle();

        // Randomized back-to-back traffic with occasional MT writes.
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 4) == 0) begin
                wait_idle();
                mt_write(1'($urandom), 1'($urandom), $urandom);
            end
            issue(2'($urandom), pick_operand(), pick_operand());
            wait_not_busy();
        end
        wait_idle();

        // Reset mid-operation discards the result.
        issue(2'b10, $urandom, 32'd13);
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_hi_lo", 64'({hi, lo}), 64'(0));
        sb_q.delete();
        cur_hi = '0;
        cur_lo = '0;
        @(negedge clk);
        rst_n = 1'b1;
        dcnt = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        chk("no_done_after_rst", 64'(dcnt), 64'(0));

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
